// File: rtl/pipe_pkg.sv
// Shared widths and packed EX-stage record types for the ID/EX boundary.
package pipe_pkg;

  localparam int DATA_W  = 32;
  localparam int REG_AW  = 5;
  localparam int ALUOP_W = 4;
  localparam int SHAMT_W = 5;

  typedef struct packed {
    logic               valid;
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic               memto_reg;
    logic               alu_src;
    logic               reg_dst;
    logic [ALUOP_W-1:0] alu_op;
  } ex_ctrl_t;

  localparam ex_ctrl_t EX_CTRL_BUBBLE = '0;

  typedef struct packed {
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
  } ex_regs_t;

  typedef struct packed {
    logic [DATA_W-1:0]  pc;
    logic [DATA_W-1:0]  rs_data;
    logic [DATA_W-1:0]  rt_data;
    logic [DATA_W-1:0]  imm;
    logic [SHAMT_W-1:0] shamt;
  } ex_data_t;

endpackage

// File: rtl/id_ex_stage_reg_if.sv
// ID-side inputs, EX-side outputs and fetch stall enables of the ID/EX register.
interface id_ex_stage_reg_if;
  import pipe_pkg::*;

  logic [DATA_W-1:0]  ID_PC, ID_RsData, ID_RtData, ID_Imm;
  logic [REG_AW-1:0]  ID_Rs, ID_Rt, ID_Rd;
  logic [SHAMT_W-1:0] ID_Shamt;
  logic               ID_UseRt;
  logic [ALUOP_W-1:0] ID_ALUOp;
  logic               ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_ALUSrc, ID_RegDst;
  logic               Flush, Hold;

  logic [DATA_W-1:0]  EX_PC, EX_RsData, EX_RtData, EX_Imm;
  logic [REG_AW-1:0]  EX_Rs, EX_Rt, EX_Rd;
  logic [SHAMT_W-1:0] EX_Shamt;
  logic [ALUOP_W-1:0] EX_ALUOp;
  logic               EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemtoReg, EX_ALUSrc, EX_RegDst;
  logic               EX_Valid;
  logic               PCWrite, IF_IDWrite;
`ifdef IDEX_PERF_CNT_EN
  logic [31:0]        BubbleCnt, HoldCnt;
`endif

  modport master (
    output ID_PC, ID_RsData, ID_RtData, ID_Imm, ID_Rs, ID_Rt, ID_Rd, ID_Shamt, ID_UseRt,
           ID_ALUOp, ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_ALUSrc,
           ID_RegDst, Flush, Hold,
    input  EX_PC, EX_RsData, EX_RtData, EX_Imm, EX_Rs, EX_Rt, EX_Rd, EX_Shamt, EX_ALUOp,
           EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemtoReg, EX_ALUSrc, EX_RegDst,
           EX_Valid, PCWrite, IF_IDWrite
`ifdef IDEX_PERF_CNT_EN
    , input BubbleCnt, HoldCnt
`endif
  );

  modport slave (
    input  ID_PC, ID_RsData, ID_RtData, ID_Imm, ID_Rs, ID_Rt, ID_Rd, ID_Shamt, ID_UseRt,
           ID_ALUOp, ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_ALUSrc,
           ID_RegDst, Flush, Hold,
    output EX_PC, EX_RsData, EX_RtData, EX_Imm, EX_Rs, EX_Rt, EX_Rd, EX_Shamt, EX_ALUOp,
           EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemtoReg, EX_ALUSrc, EX_RegDst,
           EX_Valid, PCWrite, IF_IDWrite
`ifdef IDEX_PERF_CNT_EN
    , output BubbleCnt, HoldCnt
`endif
  );

endinterface

// File: rtl/id_ex_stage_reg_load_use_detect.sv
// Combinational load-use check: a valid load in EX whose destination is read by ID.
module load_use_detect
  import pipe_pkg::*;
(
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rt,
  output logic              lu
);

  logic rt_nonzero, rs_match, rt_match;

  // $0 is hardwired, so a load "into" it never produces a dependency
  assign rt_nonzero = (ex_rt != '0);
  assign rs_match   = (ex_rt == id_rs);
  assign rt_match   = id_use_rt & (ex_rt == id_rt);
  assign lu         = ex_valid & ex_mem_read & rt_nonzero & (rs_match | rt_match);

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: 1-cycle latency, bubbles on Flush/load-use, freezes on Hold.
// Defining IDEX_PERF_CNT_EN adds saturating BubbleCnt/HoldCnt counters.
module id_ex_stage_reg
  import pipe_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  id_ex_stage_reg_if.slave bus
);

  ex_ctrl_t ctrl_q, id_ctrl;
  ex_regs_t regs_q, id_regs;
  ex_data_t data_q, id_data;
  logic     lu, bubble, keep;

  load_use_detect u_lud (
    .ex_valid    (ctrl_q.valid),
    .ex_mem_read (ctrl_q.mem_read),
    .ex_rt       (regs_q.rt),
    .id_rs       (bus.ID_Rs),
    .id_rt       (bus.ID_Rt),
    .id_use_rt   (bus.ID_UseRt),
    .lu          (lu)
  );

  always_comb begin
    id_ctrl           = EX_CTRL_BUBBLE;
    id_ctrl.valid     = 1'b1;
    id_ctrl.reg_write = bus.ID_RegWrite;
    id_ctrl.mem_read  = bus.ID_MemRead;
    id_ctrl.mem_write = bus.ID_MemWrite;
    id_ctrl.memto_reg = bus.ID_MemtoReg;
    id_ctrl.alu_src   = bus.ID_ALUSrc;
    id_ctrl.reg_dst   = bus.ID_RegDst;
    id_ctrl.alu_op    = bus.ID_ALUOp;
  end

  always_comb begin
    id_regs    = '0;
    id_regs.rs = bus.ID_Rs;
    id_regs.rt = bus.ID_Rt;
    id_regs.rd = bus.ID_Rd;
  end

  always_comb begin
    id_data         = '0;
    id_data.pc      = bus.ID_PC;
    id_data.rs_data = bus.ID_RsData;
    id_data.rt_data = bus.ID_RtData;
    id_data.imm     = bus.ID_Imm;
    id_data.shamt   = bus.ID_Shamt;
  end

  // Flush outranks Hold; Hold outranks load-use
  assign keep   = ~bus.Flush & bus.Hold;
  assign bubble = bus.Flush | (~bus.Hold & lu);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q <= EX_CTRL_BUBBLE;
      regs_q <= '0;
      data_q <= '0;
    end else if (!keep) begin
      data_q <= id_data;
      if (bubble) begin
        ctrl_q <= EX_CTRL_BUBBLE;
        regs_q <= '0;
      end else begin
        ctrl_q <= id_ctrl;
        regs_q <= id_regs;
      end
    end
  end

  // Flush deliberately absent: the redirected fetch must still be accepted
  assign bus.PCWrite    = rst | ~(lu | bus.Hold);
  assign bus.IF_IDWrite = rst | ~(lu | bus.Hold);

  assign bus.EX_PC       = data_q.pc;
  assign bus.EX_RsData   = data_q.rs_data;
  assign bus.EX_RtData   = data_q.rt_data;
  assign bus.EX_Imm      = data_q.imm;
  assign bus.EX_Shamt    = data_q.shamt;
  assign bus.EX_Rs       = regs_q.rs;
  assign bus.EX_Rt       = regs_q.rt;
  assign bus.EX_Rd       = regs_q.rd;
  assign bus.EX_ALUOp    = ctrl_q.alu_op;
  assign bus.EX_RegWrite = ctrl_q.reg_write;
  assign bus.EX_MemRead  = ctrl_q.mem_read;
  assign bus.EX_MemWrite = ctrl_q.mem_write;
  assign bus.EX_MemtoReg = ctrl_q.memto_reg;
  assign bus.EX_ALUSrc   = ctrl_q.alu_src;
  assign bus.EX_RegDst   = ctrl_q.reg_dst;
  assign bus.EX_Valid    = ctrl_q.valid;

`ifdef IDEX_PERF_CNT_EN
  logic [31:0] bubble_cnt, hold_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt <= '0;
      hold_cnt   <= '0;
    end else begin
      if (bubble && bubble_cnt != 32'hFFFF_FFFF) bubble_cnt <= bubble_cnt + 32'd1;
      if (keep && hold_cnt != 32'hFFFF_FFFF)     hold_cnt   <= hold_cnt + 32'd1;
    end
  end

  assign bus.BubbleCnt = bubble_cnt;
  assign bus.HoldCnt   = hold_cnt;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Scoreboard bench for id_ex_stage_reg: directed hazard/priority cases then random traffic.
module tb_id_ex_stage_reg;
  import pipe_pkg::*;

  // ctrl = {valid, regwrite, memread, memwrite, memtoreg, alusrc, regdst, aluop[3:0]}
  // regs = {rs, rt, rd}
  typedef struct packed {
    logic [10:0] ctrl;
    logic [14:0] regs;
    logic [4:0]  shamt;
    logic [31:0] pc, rsd, rtd, imm;
  } ex_t;

  typedef struct packed {
    logic usert;
    ex_t  f;
  } id_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  id_ex_stage_reg_if bus ();
  id_ex_stage_reg dut (.clk(clk), .rst(rst), .bus(bus));

  ex_t mdl;
  ex_t sb[$];
  int  n_vec = 0;
  int  n_bad = 0;
  int  m_bub = 0;
  int  m_hold = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic ex_t get_ex();
    ex_t a;
    a.ctrl  = {bus.EX_Valid, bus.EX_RegWrite, bus.EX_MemRead, bus.EX_MemWrite,
               bus.EX_MemtoReg, bus.EX_ALUSrc, bus.EX_RegDst, bus.EX_ALUOp};
    a.regs  = {bus.EX_Rs, bus.EX_Rt, bus.EX_Rd};
    a.shamt = bus.EX_Shamt;
    a.pc    = bus.EX_PC;
    a.rsd   = bus.EX_RsData;
    a.rtd   = bus.EX_RtData;
    a.imm   = bus.EX_Imm;
    return a;
  endfunction

  task automatic cmp_ex(input string tag, input ex_t e, input bit full);
    ex_t a;
    a = get_ex();
    check({tag, ".ctrl"}, {21'd0, a.ctrl}, {21'd0, e.ctrl});
    check({tag, ".regs"}, {17'd0, a.regs}, {17'd0, e.regs});
    if (full || e.ctrl[10]) begin
      check({tag, ".shamt"}, {27'd0, a.shamt}, {27'd0, e.shamt});
      check({tag, ".pc"},  a.pc,  e.pc);
      check({tag, ".rsd"}, a.rsd, e.rsd);
      check({tag, ".rtd"}, a.rtd, e.rtd);
      check({tag, ".imm"}, a.imm, e.imm);
    end
  endtask

  function automatic id_t mk(input int rs, input int rt, input int rd,
                             input bit rw, input bit mr, input bit usert);
    id_t v;
    v.usert   = usert;
    v.f.ctrl  = {1'b0, rw, mr, 1'b0, mr, mr, ~mr, 4'($urandom_range(0, 15))};
    v.f.regs  = {5'(rs), 5'(rt), 5'(rd)};
    v.f.shamt = 5'($urandom_range(0, 31));
    v.f.pc    = $urandom;
    v.f.rsd   = $urandom;
    v.f.rtd   = $urandom;
    v.f.imm   = $urandom;
    return v;
  endfunction

  function automatic id_t rnd_id();
    id_t v;
    v = mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    v.f.ctrl[7:4] = 4'($urandom_range(0, 15));
    return v;
  endfunction

  task automatic drive(input id_t v, input logic fl, input logic hd);
    bus.ID_UseRt    = v.usert;
    bus.ID_RegWrite = v.f.ctrl[9];
    bus.ID_MemRead  = v.f.ctrl[8];
    bus.ID_MemWrite = v.f.ctrl[7];
    bus.ID_MemtoReg = v.f.ctrl[6];
    bus.ID_ALUSrc   = v.f.ctrl[5];
    bus.ID_RegDst   = v.f.ctrl[4];
    bus.ID_ALUOp    = v.f.ctrl[3:0];
    {bus.ID_Rs, bus.ID_Rt, bus.ID_Rd} = v.f.regs;
    bus.ID_Shamt    = v.f.shamt;
    bus.ID_PC       = v.f.pc;
    bus.ID_RsData   = v.f.rsd;
    bus.ID_RtData   = v.f.rtd;
    bus.ID_Imm      = v.f.imm;
    bus.Flush       = fl;
    bus.Hold        = hd;
  endtask

  function automatic logic model_lu(input id_t v);
    logic [4:0] ert;
    ert = mdl.regs[9:5];
    return mdl.ctrl[10] & mdl.ctrl[8] & (ert != 5'd0) &
           ((ert == v.f.regs[14:10]) | (v.usert & (ert == v.f.regs[9:5])));
  endfunction

  // One ID cycle: drive at negedge, check stall enables, predict, compare after posedge
  task automatic step(input string tag, input id_t v, input logic fl, input logic hd);
    ex_t nxt, e;
    logic lu;
    @(negedge clk);
    drive(v, fl, hd);
    lu = model_lu(v);
    #1;
    check({tag, ".pcwrite"}, {31'd0, bus.PCWrite}, {31'd0, ~(lu | hd)});
    check({tag, ".ifidwrite"}, {31'd0, bus.IF_IDWrite}, {31'd0, ~(lu | hd)});
    nxt = mdl;
    if (fl || (!hd && lu)) begin
      nxt = v.f;
      nxt.ctrl = '0;
      nxt.regs = '0;
      m_bub++;
    end else if (hd) begin
      m_hold++;
    end else begin
      nxt = v.f;
      nxt.ctrl[10] = 1'b1;
    end
    sb.push_back(nxt);
    mdl = nxt;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    cmp_ex(tag, e, 1'b0);
  endtask

  task automatic check_cnt(input string tag);
`ifdef IDEX_PERF_CNT_EN
    check({tag, ".bubblecnt"}, bus.BubbleCnt, 32'(m_bub));
    check({tag, ".holdcnt"},   bus.HoldCnt,   32'(m_hold));
`else
    if (tag.len() == 0) $display("empty tag");
`endif
  endtask

  id_t add3, lw5, use5, lw0, use0, lw6, lw7, use7, v;

  initial begin
    drive(mk(0, 0, 0, 0, 0, 0), 1'b0, 1'b1);
    mdl = '0;
    #3;
    cmp_ex("reset", '0, 1'b1);
    check("reset.pcwrite", {31'd0, bus.PCWrite}, 32'd1);
    check("reset.ifidwrite", {31'd0, bus.IF_IDWrite}, 32'd1);
    check_cnt("reset");
    @(negedge clk);
    rst = 1'b0;

    add3 = mk(1, 2, 3, 1, 0, 1);
    step("add", add3, 0, 0);
    check("add.rs", {27'd0, bus.EX_Rs}, 32'd1);
    check("add.rt", {27'd0, bus.EX_Rt}, 32'd2);
    check("add.rd", {27'd0, bus.EX_Rd}, 32'd3);

    lw5  = mk(1, 5, 0, 1, 1, 0);
    use5 = mk(5, 4, 6, 1, 0, 1);
    step("lw5", lw5, 0, 0);
    step("lu.stall", use5, 0, 0);
    check("lu.bubble", {31'd0, bus.EX_Valid}, 32'd0);
    step("lu.consume", use5, 0, 0);
    check("lu.loaded", {31'd0, bus.EX_Valid}, 32'd1);

    step("lw5b", lw5, 0, 0);
    step("rt_gate", mk(2, 5, 7, 1, 0, 0), 0, 0);
    lw0  = mk(1, 0, 0, 1, 1, 0);
    use0 = mk(0, 0, 8, 1, 0, 1);
    step("lw0", lw0, 0, 0);
    step("zero_reg", use0, 0, 0);

    lw6  = mk(1, 6, 0, 1, 1, 0);
    lw7  = mk(2, 7, 0, 1, 1, 0);
    use7 = mk(7, 3, 9, 1, 0, 1);
    step("b2b.lw6", lw6, 0, 0);
    step("b2b.lw7", lw7, 0, 0);
    step("b2b.stall", use7, 0, 0);
    step("b2b.consume", use7, 0, 0);

    step("prio.lw", lw5, 0, 0);
    step("prio.all", use5, 1, 1);
    step("prio.lw2", lw5, 0, 0);
    step("prio.hold_lu", use5, 0, 1);
    step("prio.hold_lu2", use5, 0, 1);
    step("prio.release", use5, 0, 0);
    step("prio.consume", use5, 0, 0);
    check_cnt("directed");

    // Reset while a load-use stall is pending
    step("rstmid.lw", lw5, 0, 0);
    @(negedge clk);
    drive(use5, 1'b0, 1'b0);
    #1;
    check("rstmid.stall", {31'd0, bus.PCWrite}, 32'd0);
    #1;
    rst = 1'b1;
    #1;
    cmp_ex("rstmid", '0, 1'b1);
    check("rstmid.pcwrite", {31'd0, bus.PCWrite}, 32'd1);
    mdl = '0;
    m_bub = 0;
    m_hold = 0;
    check_cnt("rstmid");
    @(negedge clk);
    rst = 1'b0;
    step("post_rst", use5, 0, 0);

    for (int i = 0; i < 300; i++) begin
      v = rnd_id();
      step("rnd", v, 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 5) == 0));
    end
    check_cnt("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
